matrix_result_buffer: RTL and testbench

Serial-to-parallel capture stage upstream of the 7-segment result display. It accepts the coprocessor's 25 signed 8-bit result elements one per handshake and packs them into the flat 200-bit matrix_out bus the display stage scans. It also generates the slow display step clock clk_1_segundo from the system clock.

---
 rtl/matrix_result_buffer_if.sv | 44 ++++
 rtl/matrix_result_buffer.sv | 127 ++++++++++++
 tb/tb_matrix_result_buffer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/matrix_result_buffer_if.sv
// matrix_result_buffer_if: element handshake and packed-result bus of the result capture stage.
// Revision 1.0
`default_nettype none

interface matrix_result_buffer_if #(
  parameter int N_ELEM = 25,
  parameter int ELEM_W = 8
);
  logic                       start;
  logic                       in_valid;
  logic [ELEM_W-1:0]          in_data;
  logic                       in_ready;
  logic [N_ELEM*ELEM_W-1:0]   matrix_out;
  logic [4:0]                 elem_count;
  logic                       busy;
  logic                       done;
  logic                       err;

  modport master (
    output start,
    output in_valid,
    output in_data,
    input  in_ready,
    input  matrix_out,
    input  elem_count,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  start,
    input  in_valid,
    input  in_data,
    output in_ready,
    output matrix_out,
    output elem_count,
    output busy,
    output done,
    output err
  );
endinterface

`default_nettype wire

// File: rtl/matrix_result_buffer.sv
// matrix_result_buffer: serial-to-parallel capture of 5x5 signed results plus 1 Hz display step clock.
// Revision 1.0
`default_nettype none

module matrix_result_buffer #(
  parameter int N_ELEM      = 25,
  parameter int ELEM_W      = 8,
  parameter int HALF_PERIOD = 25_000_000
) (
  input  wire logic                clk,
  input  wire logic                reset_n,
  matrix_result_buffer_if.slave    bus,
  output logic                     clk_1_segundo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FULL = 2'd2
  } state_e;

  localparam logic [4:0] c_last_idx = 5'(N_ELEM - 1);
  localparam int         c_cnt_w    = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [c_cnt_w-1:0] c_div_last = c_cnt_w'(HALF_PERIOD - 1);

  state_e                   state_q;
  logic [4:0]               count_q;
  logic                     err_q;
  logic                     w_load;
  logic                     w_hs;
  logic [ELEM_W-1:0]        elem_q [N_ELEM];
  logic [N_ELEM*ELEM_W-1:0] w_matrix;

  logic [c_cnt_w-1:0]       div_q;
  logic [c_cnt_w-1:0]       div_d;
  logic                     seg_q;
  logic                     seg_d;

  // A start cycle always wins over data: that cycle's element is discarded.
  assign w_load = (state_q == S_LOAD);
  assign w_hs   = w_load && bus.in_valid && !bus.start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_FULL: begin
          if (bus.start) begin
            state_q <= S_LOAD;
            count_q <= '0;
            err_q   <= 1'b0;
          end else if (bus.in_valid) begin
            err_q   <= 1'b1;
          end
        end
        S_LOAD: begin
          if (bus.start) begin
            count_q <= '0;
            err_q   <= 1'b0;
          end else if (bus.in_valid) begin
            count_q <= count_q + 5'd1;
            if (count_q == c_last_idx) begin
              state_q <= S_FULL;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          count_q <= '0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  // One register per element; the write pointer is the running element count.
  for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_elem
    localparam logic [4:0] c_idx = 5'(gi);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        elem_q[gi] <= '0;
      end else if (bus.start) begin
        elem_q[gi] <= '0;
      end else if (w_hs && (count_q == c_idx)) begin
        elem_q[gi] <= bus.in_data;
      end
    end

    assign w_matrix[gi*ELEM_W +: ELEM_W] = elem_q[gi];
  end

  assign bus.matrix_out = w_matrix;
  assign bus.elem_count = count_q;
  assign bus.in_ready   = w_load;
  assign bus.busy       = w_load;
  assign bus.done       = (state_q == S_FULL);
  assign bus.err        = err_q;

  // Free-running divider, deliberately independent of the capture FSM.
  always_comb begin
    div_d = div_q + c_cnt_w'(1);
    seg_d = seg_q;
    if (div_q == c_div_last) begin
      div_d = '0;
      seg_d = ~seg_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      seg_q <= 1'b0;
    end else begin
      div_q <= div_d;
      seg_q <= seg_d;
    end
  end

  assign clk_1_segundo = seg_q;

endmodule

`default_nettype wire

// File: tb/tb_matrix_result_buffer.sv
// tb_matrix_result_buffer: table-driven and scoreboard checks of the result capture stage.
// Revision 1.0
`default_nettype none

module tb_matrix_result_buffer;

  localparam int N  = 25;
  localparam int W  = 8;
  localparam int HP = 2;

  typedef struct {
    logic       s;
    logic       v;
    logic [7:0] d;
    logic       acc;
    int         cnt;
    logic       busy;
    logic       done;
    logic       err;
  } vec_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  logic clk_1s;

  int n_chk  = 0;
  int n_fail = 0;
  int k      = 0;

  logic [7:0] sb_q [$];
  vec_t       tbl  [$];

  matrix_result_buffer_if #(.N_ELEM(N), .ELEM_W(W)) bus ();

  matrix_result_buffer #(
    .N_ELEM      (N),
    .ELEM_W      (W),
    .HALF_PERIOD (HP)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus),
    .clk_1_segundo (clk_1s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] el(input int i);
    return bus.matrix_out[i*W +: W];
  endfunction

  task automatic step(input logic s, input logic v, input logic [7:0] d);
    bus.start    = s;
    bus.in_valid = v;
    bus.in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic sb_check(input string nm);
    logic [7:0] e;
    for (int i = 0; i < N; i++) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s: scoreboard empty at element %0d", nm, i);
      end else begin
        e = sb_q.pop_front();
        chk(nm, el(i), e);
      end
    end
    chk({nm, "_left"}, sb_q.size(), 0);
  endtask

  // Display step clock: 0 at reset, then toggles every HP=2 edges regardless of capture activity.
  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      k = 0;
      chk("div_rst", clk_1s, 0);
    end else begin
      k++;
      chk("div_phase", clk_1s, (k / 2) % 2);
    end
  end

  initial begin
    vec_t r;
    int   acc;
    logic v;
    logic [7:0] d;

    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_matrix", bus.matrix_out, 0);
    chk("rst_count",  bus.elem_count, 0);
    chk("rst_busy",   bus.busy, 0);
    chk("rst_done",   bus.done, 0);
    chk("rst_err",    bus.err, 0);
    chk("rst_ready",  bus.in_ready, 0);
    chk("rst_clk1s",  clk_1s, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;

    step(1'b0, 1'b1, 8'h33);
    chk("idle_err",   bus.err, 1);
    chk("idle_count", bus.elem_count, 0);
    chk("idle_busy",  bus.busy, 0);

    // Table: start, 25 accepts of i-12, then an offer while FULL.
    tbl.push_back('{s:1'b1, v:1'b0, d:8'h00, acc:1'b0, cnt:0, busy:1'b1, done:1'b0, err:1'b0});
    for (int i = 0; i < N; i++) begin
      tbl.push_back('{s:1'b0, v:1'b1, d:8'(i - 12), acc:1'b1, cnt:i + 1,
                      busy:(i < N - 1), done:(i == N - 1), err:1'b0});
    end
    tbl.push_back('{s:1'b0, v:1'b1, d:8'h55, acc:1'b0, cnt:N, busy:1'b0, done:1'b1, err:1'b1});

    foreach (tbl[j]) begin
      r = tbl[j];
      if (r.acc) sb_q.push_back(r.d);
      step(r.s, r.v, r.d);
      chk("tbl_count", bus.elem_count, r.cnt);
      chk("tbl_busy",  bus.busy, r.busy);
      chk("tbl_done",  bus.done, r.done);
      chk("tbl_err",   bus.err, r.err);
      chk("tbl_ready", bus.in_ready, r.busy);
    end
    sb_check("seq_elem");
    chk("seq_e0",  bus.matrix_out[7:0],     8'hF4);
    chk("seq_e12", bus.matrix_out[103:96],  8'h00);
    chk("seq_e24", bus.matrix_out[199:192], 8'h0C);

    step(1'b1, 1'b0, 8'h00);
    chk("restart_err",    bus.err, 0);
    chk("restart_matrix", bus.matrix_out, 0);
    chk("restart_busy",   bus.busy, 1);
    chk("restart_count",  bus.elem_count, 0);

    // Gapped stream alternating 0x80 / 0x7F.
    acc = 0;
    for (int c = 0; c < 2 * N; c++) begin
      v = (c % 2 == 0);
      d = (acc % 2 == 0) ? 8'h80 : 8'h7F;
      if (v) begin
        sb_q.push_back(d);
        acc++;
      end
      step(1'b0, v, d);
    end
    chk("gap_count", bus.elem_count, N);
    chk("gap_done",  bus.done, 1);
    chk("gap_ready", bus.in_ready, 0);
    chk("gap_e0",    el(0), 8'h80);
    chk("gap_e1",    el(1), 8'h7F);
    sb_check("gap_elem");

    // Restart mid-capture with valid data on the start cycle.
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'(8'h10 + i));
    chk("mid_count7", bus.elem_count, 7);
    step(1'b1, 1'b1, 8'hAA);
    chk("mid_count0", bus.elem_count, 0);
    chk("mid_matrix", bus.matrix_out, 0);
    chk("mid_busy",   bus.busy, 1);
    step(1'b0, 1'b1, 8'h3C);
    chk("mid_e0",     el(0), 8'h3C);
    chk("mid_e1",     el(1), 8'h00);
    chk("mid_count1", bus.elem_count, 1);

    // Asynchronous reset after 10 elements.
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'(i + 1));
    chk("ar_count10", bus.elem_count, 10);
    bus.in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("ar_matrix", bus.matrix_out, 0);
    chk("ar_count",  bus.elem_count, 0);
    chk("ar_busy",   bus.busy, 0);
    chk("ar_done",   bus.done, 0);
    chk("ar_err",    bus.err, 0);
    chk("ar_ready",  bus.in_ready, 0);
    chk("ar_clk1s",  clk_1s, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ar_idle_busy", bus.busy, 0);

    // Capture traffic while the divider keeps running.
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 12; i++) step(1'b0, (i % 3 != 0), 8'(i));
    step(1'b1, 1'b1, 8'hEE);
    chk("act_count", bus.elem_count, 0);
    repeat (5) step(1'b0, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
